// File: rtl/scr1_core2axi_bridge_if.sv
// AXI4 single-beat master/slave bundle used by scr1_core2axi_bridge.
interface scr1_core2axi_bridge_if #(
  parameter int unsigned W_ID  = 4,
  parameter int unsigned W_ADR = 32
);
  logic             awvalid;
  logic             awready;
  logic [W_ID-1:0]  awid;
  logic [W_ADR-1:0] awaddr;
  logic [2:0]       awsize;
  logic [7:0]       awlen;
  logic             wvalid;
  logic             wready;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             wlast;
  logic             bvalid;
  logic             bready;
  logic [W_ID-1:0]  bid;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [W_ID-1:0]  arid;
  logic [W_ADR-1:0] araddr;
  logic [1:0]       arburst;
  logic [2:0]       arsize;
  logic [7:0]       arlen;
  logic             rvalid;
  logic             rready;
  logic [W_ID-1:0]  rid;
  logic [31:0]      rdata;
  logic             rlast;
  logic [1:0]       rresp;

  modport master (
    output awvalid, awid, awaddr, awsize, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, arid, araddr, arburst, arsize, arlen,
    output rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rid, rdata, rlast, rresp
  );

  modport slave (
    input  awvalid, awid, awaddr, awsize, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, arid, araddr, arburst, arsize, arlen,
    input  rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rid, rdata, rlast, rresp
  );
endinterface

// File: rtl/scr1_core2axi_bridge.sv
// SCR1 core memory port to single-beat AXI4 master, one transaction in flight.
module scr1_core2axi_bridge #(
  parameter int unsigned W_ID   = 4,
  parameter int unsigned W_ADR  = 32,
  parameter int unsigned ID_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  output logic                  core_req_ack,
  input  logic                  core_cmd,
  input  logic [1:0]            core_width,
  input  logic [W_ADR-1:0]      core_addr,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic [1:0]            core_resp,
  scr1_core2axi_bridge_if.master axi
);

  localparam logic [1:0] RespIdle = 2'd0;
  localparam logic [1:0] RespRdy  = 2'd1;
  localparam logic [1:0] RespErr  = 2'd2;
  localparam logic [W_ID-1:0] IdVal = W_ID'(ID_VAL);

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWaddr, StWresp, StResp, StErrs} state_e;

  state_e           state_q, state_d;
  logic [1:0]       width_q;
  logic [W_ADR-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             aw_done_q, w_done_q;
  logic             misaligned;
  logic             ack;
  logic             aw_fin, w_fin;
  logic [1:0]       lane;
  logic [31:0]      rd_shift, rd_steer;
  logic             r_bad, b_bad;

  assign lane = addr_q[1:0];

  // Illegal width or unaligned half/word is trapped before any bus activity
  always_comb begin
    unique case (core_width)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = core_addr[0];
      2'd2:    misaligned = (core_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign ack    = (state_q == StIdle) && core_req;
  assign aw_fin = aw_done_q || axi.awready;
  assign w_fin  = w_done_q || axi.wready;
  assign r_bad  = (axi.rresp != 2'b00) || (axi.rid != IdVal) || !axi.rlast;
  assign b_bad  = (axi.bresp != 2'b00) || (axi.bid != IdVal);

  // Read steering: shift selected lane down, then zero bits above the access width
  always_comb begin
    rd_shift = axi.rdata >> {lane, 3'b000};
    unique case (width_q)
      2'd0:    rd_steer = {24'h0, rd_shift[7:0]};
      2'd1:    rd_steer = {16'h0, rd_shift[15:0]};
      default: rd_steer = rd_shift;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (core_req) begin
          if (misaligned)    state_d = StErrs;
          else if (core_cmd) state_d = StWaddr;
          else               state_d = StRaddr;
        end
      end
      StRaddr: if (axi.arready) state_d = StRdata;
      StRdata: if (axi.rvalid) state_d = StResp;
      StWaddr: if (aw_fin && w_fin) state_d = StWresp;
      StWresp: if (axi.bvalid) state_d = StResp;
      StResp:  state_d = StIdle;
      StErrs:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request payload, channel completion flags, read data and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q   <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (ack) begin
        width_q   <= core_width;
        addr_q    <= core_addr;
        wdata_q   <= core_wdata;
        rdata_q   <= '0;
        err_q     <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state_q == StWaddr) begin
        aw_done_q <= aw_fin;
        w_done_q  <= w_fin;
      end
      if (state_q == StRdata && axi.rvalid) begin
        rdata_q <= rd_steer;
        err_q   <= r_bad;
      end
      if (state_q == StWresp && axi.bvalid) err_q <= b_bad;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    core_req_ack = ack;
    core_resp    = RespIdle;
    core_rdata   = 32'h0;
    axi.arvalid  = (state_q == StRaddr);
    axi.rready   = (state_q == StRdata);
    axi.awvalid  = (state_q == StWaddr) && !aw_done_q;
    axi.wvalid   = (state_q == StWaddr) && !w_done_q;
    axi.bready   = (state_q == StWresp);
    if (state_q == StResp) begin
      core_resp  = err_q ? RespErr : RespRdy;
      core_rdata = rdata_q;
    end else if (state_q == StErrs) begin
      core_resp  = RespErr;
    end
  end

  // Address/data payload: word-aligned address, lane-replicated data and strobes
  always_comb begin
    axi.awid    = IdVal;
    axi.arid    = IdVal;
    axi.awaddr  = {addr_q[W_ADR-1:2], 2'b00};
    axi.araddr  = {addr_q[W_ADR-1:2], 2'b00};
    axi.awsize  = {1'b0, width_q};
    axi.arsize  = {1'b0, width_q};
    axi.awlen   = 8'd0;
    axi.arlen   = 8'd0;
    axi.arburst = 2'b01;
    axi.wlast   = 1'b1;
    unique case (width_q)
      2'd0: begin
        axi.wdata = {4{wdata_q[7:0]}};
        axi.wstrb = 4'b0001 << lane;
      end
      2'd1: begin
        axi.wdata = {2{wdata_q[15:0]}};
        axi.wstrb = 4'b0011 << lane;
      end
      default: begin
        axi.wdata = wdata_q;
        axi.wstrb = 4'hF;
      end
    endcase
  end

endmodule

// File: tb/tb_scr1_core2axi_bridge.sv
// Directed bench for scr1_core2axi_bridge with a small AXI memory slave model.
module tb_scr1_core2axi_bridge;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_req_ack;
  logic        core_cmd;
  logic [1:0]  core_width;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic [1:0]  core_resp;

  scr1_core2axi_bridge_if #(.W_ID(4), .W_ADR(32)) bus ();

  scr1_core2axi_bridge #(.W_ID(4), .W_ADR(32), .ID_VAL(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req     (core_req),
    .core_req_ack (core_req_ack),
    .core_cmd     (core_cmd),
    .core_width   (core_width),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .core_resp    (core_resp),
    .axi          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave controls, driven by the stimulus process
  int         aw_delay  = 0;
  logic       hold_r    = 1'b0;
  logic [3:0] rid_val   = 4'd0;
  logic [1:0] bresp_val = 2'd0;
  logic       mon_clr   = 1'b0;

  // Slave model state
  logic [7:0]  mem [0:4095];
  int          aw_wait;
  logic        aw_got, w_got, aw_hs, w_hs, aw_now, w_now;
  logic [11:0] ra;
  logic [31:0] cap_awaddr, cap_araddr, cap_wdata;
  logic [2:0]  cap_awsize, cap_arsize;
  logic [3:0]  cap_wstrb;

  assign bus.awready = (aw_wait >= aw_delay);
  assign bus.wready  = 1'b1;
  assign bus.arready = 1'b1;

  // Memory slave: write on W beat, B after both AW and W, R one cycle after AR
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h100] <= 8'h11;
      mem[12'h101] <= 8'h22;
      mem[12'h102] <= 8'h33;
      mem[12'h103] <= 8'h44;
      aw_wait    <= 0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      bus.bvalid <= 1'b0;
      bus.bid    <= '0;
      bus.bresp  <= '0;
      bus.rvalid <= 1'b0;
      bus.rid    <= '0;
      bus.rdata  <= '0;
      bus.rlast  <= 1'b0;
      bus.rresp  <= '0;
      cap_awaddr <= '0;
      cap_araddr <= '0;
      cap_wdata  <= '0;
      cap_awsize <= '0;
      cap_arsize <= '0;
      cap_wstrb  <= '0;
    end else begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      if (aw_hs) begin
        cap_awaddr <= bus.awaddr;
        cap_awsize <= bus.awsize;
      end
      if (w_hs) begin
        cap_wdata <= bus.wdata;
        cap_wstrb <= bus.wstrb;
        for (int l = 0; l < 4; l++)
          if (bus.wstrb[l]) mem[{bus.awaddr[11:2], 2'(l)}] <= bus.wdata[8*l +: 8];
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      aw_now = aw_got || aw_hs;
      w_now  = w_got || w_hs;
      if (aw_now && w_now) begin
        bus.bvalid <= 1'b1;
        bus.bid    <= rid_val;
        bus.bresp  <= bresp_val;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else begin
        aw_got <= aw_now;
        w_got  <= w_now;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        cap_araddr <= bus.araddr;
        cap_arsize <= bus.arsize;
        ra = {bus.araddr[11:2], 2'b00};
        if (!hold_r) begin
          bus.rvalid <= 1'b1;
          bus.rdata  <= {mem[ra | 12'd3], mem[ra | 12'd2], mem[ra | 12'd1], mem[ra]};
          bus.rid    <= rid_val;
          bus.rresp  <= 2'b00;
          bus.rlast  <= 1'b1;
        end
      end
    end
  end

  // Activity monitor: valid-cycle counts, AW payload stability, response pulses
  int          ar_cyc, aw_cyc, w_cyc, resp_cyc, aw_unstable;
  logic        prev_awv;
  logic [31:0] prev_awaddr;
  always @(negedge clk) begin
    if (mon_clr) begin
      ar_cyc <= 0; aw_cyc <= 0; w_cyc <= 0; resp_cyc <= 0; aw_unstable <= 0;
      prev_awv <= 1'b0;
    end else begin
      if (bus.arvalid) ar_cyc <= ar_cyc + 1;
      if (bus.awvalid) aw_cyc <= aw_cyc + 1;
      if (bus.wvalid)  w_cyc  <= w_cyc + 1;
      if (core_resp != 2'd0) resp_cyc <= resp_cyc + 1;
      if (bus.awvalid && prev_awv && bus.awaddr != prev_awaddr) aw_unstable <= aw_unstable + 1;
      prev_awv    <= bus.awvalid;
      prev_awaddr <= bus.awaddr;
    end
  end

  task automatic mon_reset();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  // One core request; lat counts cycles from the ack cycle to the response cycle
  task automatic do_req(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, output logic [1:0] resp,
                        output logic [31:0] rdata, output int lat, output logic acked);
    @(posedge clk); #1;
    core_req = 1'b1; core_cmd = cmd; core_width = w; core_addr = a; core_wdata = d;
    @(negedge clk);
    acked = core_req_ack;
    @(posedge clk); #1;
    core_req = 1'b0;
    resp = 2'd0; rdata = 32'h0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (core_resp != 2'd0) begin
        resp = core_resp; rdata = core_rdata; lat = i;
        break;
      end
    end
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  int          lat;
  logic        acked;

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_cmd = 1'b0; core_width = 2'd0;
    core_addr = 32'h0; core_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp", 32'(core_resp), 32'd0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_valids", {27'h0, bus.arvalid, bus.awvalid, bus.wvalid, bus.bready, bus.rready}, 32'h0);
    check("rst_ack", 32'(core_req_ack), 32'd0);
    #1 rst_n = 1'b1;

    // Word read with minimum latency
    mon_reset();
    do_req(1'b0, 2'd2, 32'h100, 32'h0, resp, rd, lat, acked);
    check("rd_word_ack", 32'(acked), 32'd1);
    check("rd_word_resp", 32'(resp), 32'd1);
    check("rd_word_data", rd, 32'h44332211);
    check("rd_word_lat", 32'(lat), 32'd3);
    check("rd_word_araddr", cap_araddr, 32'h100);
    check("rd_word_arsize", 32'(cap_arsize), 32'd2);
    check("rd_word_arcyc", 32'(ar_cyc), 32'd1);

    // Byte write to lane 3
    do_req(1'b1, 2'd0, 32'h203, 32'h000000AB, resp, rd, lat, acked);
    check("wr_byte_resp", 32'(resp), 32'd1);
    check("wr_byte_lat", 32'(lat), 32'd3);
    check("wr_byte_awaddr", cap_awaddr, 32'h200);
    check("wr_byte_awsize", 32'(cap_awsize), 32'd0);
    check("wr_byte_wdata", cap_wdata, 32'hABABABAB);
    check("wr_byte_wstrb", 32'(cap_wstrb), 32'h8);

    // Byte readback from lane 3, half read from lane 2
    do_req(1'b0, 2'd0, 32'h203, 32'h0, resp, rd, lat, acked);
    check("rd_byte_data", rd, 32'h000000AB);
    check("rd_byte_araddr", cap_araddr, 32'h200);
    do_req(1'b0, 2'd1, 32'h102, 32'h0, resp, rd, lat, acked);
    check("rd_half_data", rd, 32'h00004433);
    check("rd_half_arsize", 32'(cap_arsize), 32'd1);

    // Half write at odd address is trapped locally
    mon_reset();
    do_req(1'b1, 2'd1, 32'h301, 32'h1234, resp, rd, lat, acked);
    check("mis_resp", 32'(resp), 32'd2);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_rdata", rd, 32'h0);
    check("mis_bus_cyc", 32'(ar_cyc + aw_cyc + w_cyc), 32'd0);

    // Width 3 is illegal
    do_req(1'b0, 2'd3, 32'h100, 32'h0, resp, rd, lat, acked);
    check("w3_resp", 32'(resp), 32'd2);

    // AW stalled two cycles, W accepted at once
    aw_delay = 2;
    mon_reset();
    do_req(1'b1, 2'd2, 32'h400, 32'hDEADBEEF, resp, rd, lat, acked);
    check("awst_resp", 32'(resp), 32'd1);
    check("awst_lat", 32'(lat), 32'd5);
    check("awst_awcyc", 32'(aw_cyc), 32'd3);
    check("awst_wcyc", 32'(w_cyc), 32'd1);
    check("awst_stable", 32'(aw_unstable), 32'd0);
    check("awst_wstrb", 32'(cap_wstrb), 32'hF);
    @(negedge clk);
    check("awst_resp_cyc", 32'(resp_cyc), 32'd1);
    aw_delay = 0;
    do_req(1'b0, 2'd2, 32'h400, 32'h0, resp, rd, lat, acked);
    check("awst_readback", rd, 32'hDEADBEEF);

    // Slave error response on B, then a normal request
    bresp_val = 2'b10;
    do_req(1'b1, 2'd2, 32'h500, 32'h1, resp, rd, lat, acked);
    check("bresp_err", 32'(resp), 32'd2);
    bresp_val = 2'b00;
    do_req(1'b0, 2'd2, 32'h100, 32'h0, resp, rd, lat, acked);
    check("after_err_ack", 32'(acked), 32'd1);
    check("after_err_resp", 32'(resp), 32'd1);

    // Wrong RID
    rid_val = 4'd5;
    do_req(1'b0, 2'd2, 32'h100, 32'h0, resp, rd, lat, acked);
    check("rid_err", 32'(resp), 32'd2);
    rid_val = 4'd0;

    // Reset while waiting in RDATA
    hold_r = 1'b1;
    mon_reset();
    @(posedge clk); #1;
    core_req = 1'b1; core_cmd = 1'b0; core_width = 2'd2; core_addr = 32'h100;
    @(posedge clk); #1 core_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_rready_pre", 32'(bus.rready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rready", 32'(bus.rready), 32'd0);
    check("rst_mid_arvalid", 32'(bus.arvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; hold_r = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_noresp", 32'(resp_cyc), 32'd0);
    do_req(1'b0, 2'd2, 32'h100, 32'h0, resp, rd, lat, acked);
    check("rst_mid_clean_resp", 32'(resp), 32'd1);
    check("rst_mid_clean_data", rd, 32'h44332211);
    check("rst_mid_clean_lat", 32'(lat), 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
